axi_lite_split_mem: RTL and testbench

// - AXI4-Lite slave memory that sits directly downstream of the core's M_AXI master port.
// - Serves instruction fetches and load/store traffic from two word arrays:
//   - i_data: instruction region.
//   - d_data: data region.
// - Arrays are preloadable by simulation $readmemh through hierarchical names i_data / d_data.
// - Synthesizable replacement for the behavioural memory mock in core-level benches.
//

---
 rtl/axi_lite_split_mem.sv | 196 +++++++++++++++++++
 tb/tb_axi_lite_split_mem.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_split_mem.sv
// rtl/axi_lite_split_mem.sv - AXI4-Lite slave with split instruction/data word arrays
// Optional AXI_MEM_LATENCY_EN adds LATENCY wait cycles to each BUSY state.
module axi_lite_split_mem #(
  parameter logic [31:0] I_BASE  = 32'h0000_0000,
  parameter int          I_DEPTH = 1024,
  parameter logic [31:0] D_BASE  = 32'h0001_0000,
  parameter int          D_DEPTH = 1024,
  parameter int          LATENCY = 3
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  output logic [1:0]  S_AXI_BRESP,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [2:0]  S_AXI_ARPROT,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP
);

  localparam int          IW      = $clog2(I_DEPTH);
  localparam int          DW      = $clog2(D_DEPTH);
  localparam logic [31:0] I_BYTES = 32'(4 * I_DEPTH);
  localparam logic [31:0] D_BYTES = 32'(4 * D_DEPTH);
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  DECERR  = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_BUSY, R_DATA} r_state_t;

  logic [31:0] i_data [0:I_DEPTH-1];
  logic [31:0] d_data [0:D_DEPTH-1];

  w_state_t    w_state, w_state_n;
  r_state_t    r_state, r_state_n;
  logic        aw_held, w_held;
  logic [31:0] aw_addr, w_data, ar_addr;
  logic [3:0]  w_strb;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data;
  logic        aw_hs, w_hs, ar_hs, w_done, r_done, w_commit;

  // Offsets from each region base; unsigned compare also rejects addresses below base
  logic [31:0] aw_off_i, aw_off_d, ar_off_i, ar_off_d;
  logic        w_hit_i, w_hit_d, r_hit_i, r_hit_d;

  assign aw_off_i = aw_addr - I_BASE;
  assign aw_off_d = aw_addr - D_BASE;
  assign ar_off_i = ar_addr - I_BASE;
  assign ar_off_d = ar_addr - D_BASE;
  assign w_hit_i  = (aw_addr >= I_BASE) && (aw_off_i < I_BYTES);
  assign w_hit_d  = (aw_addr >= D_BASE) && (aw_off_d < D_BYTES);
  assign r_hit_i  = (ar_addr >= I_BASE) && (ar_off_i < I_BYTES);
  assign r_hit_d  = (ar_addr >= D_BASE) && (ar_off_d < D_BYTES);

  // Readies are gated by RSTn so they read 0 throughout reset
  assign S_AXI_AWREADY = RSTn && (w_state == W_IDLE) && !aw_held;
  assign S_AXI_WREADY  = RSTn && (w_state == W_IDLE) && !w_held;
  assign S_AXI_ARREADY = RSTn && (r_state == R_IDLE);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_BRESP   = b_resp;
  assign S_AXI_RRESP   = r_resp;
  assign S_AXI_RDATA   = r_data;

  assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_commit = (w_state == W_BUSY) && w_done;

  always_comb begin
    w_state_n = w_state;
    case (w_state)
      W_IDLE: if ((aw_held || aw_hs) && (w_held || w_hs)) w_state_n = W_BUSY;
      W_BUSY: if (w_done) w_state_n = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_state_n = R_BUSY;
      R_BUSY: if (r_done) r_state_n = R_DATA;
      R_DATA: if (S_AXI_RREADY) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      b_resp  <= OKAY;
    end else begin
      w_state <= w_state_n;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (w_commit) b_resp <= (w_hit_i || w_hit_d) ? OKAY : DECERR;
      if (w_state == W_RESP && S_AXI_BREADY) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= R_IDLE;
      ar_addr <= '0;
      r_data  <= '0;
      r_resp  <= OKAY;
    end else begin
      r_state <= r_state_n;
      if (ar_hs) ar_addr <= S_AXI_ARADDR;
      if (r_state == R_BUSY && r_done) begin
        if (r_hit_i) begin
          r_data <= i_data[ar_off_i[IW+1:2]];
          r_resp <= OKAY;
        end else if (r_hit_d) begin
          r_data <= d_data[ar_off_d[DW+1:2]];
          r_resp <= OKAY;
        end else begin
          r_data <= '0;
          r_resp <= DECERR;
        end
      end
    end
  end

  // Arrays are never reset so preloaded images survive RSTn
  always_ff @(posedge CLK) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) begin
          if (w_hit_i) i_data[aw_off_i[IW+1:2]][8*b +: 8] <= w_data[8*b +: 8];
          if (w_hit_d) d_data[aw_off_d[DW+1:2]][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

`ifdef AXI_MEM_LATENCY_EN
  logic [7:0] w_cnt, r_cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      w_cnt <= '0;
      r_cnt <= '0;
    end else begin
      if (w_state != W_BUSY && w_state_n == W_BUSY) w_cnt <= 8'(LATENCY);
      else if (w_state == W_BUSY && w_cnt != 8'd0) w_cnt <= w_cnt - 8'd1;
      if (r_state != R_BUSY && r_state_n == R_BUSY) r_cnt <= 8'(LATENCY);
      else if (r_state == R_BUSY && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
    end
  end

  assign w_done = (w_cnt == 8'd0);
  assign r_done = (r_cnt == 8'd0);
`else
  logic [7:0] unused_latency;
  assign unused_latency = 8'(LATENCY);
  assign w_done = 1'b1;
  assign r_done = 1'b1;
`endif

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         aw_off_i[31:IW+2], aw_off_i[1:0], aw_off_d[31:DW+2], aw_off_d[1:0],
                         ar_off_i[31:IW+2], ar_off_i[1:0], ar_off_d[31:DW+2], ar_off_d[1:0]};

endmodule

// File: tb/tb_axi_lite_split_mem.sv
// tb/tb_axi_lite_split_mem.sv - scoreboard bench for axi_lite_split_mem
module tb_axi_lite_split_mem;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;
  localparam int         BOUND  = 60;
  localparam int         LAT    = 3;
`ifdef AXI_MEM_LATENCY_EN
  localparam int EXP_LAT = 2 + LAT;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic [1:0] exp_b [$];
  rexp_t      exp_r [$];
  int         checks = 0;
  int         fails  = 0;

  always #5 clk = ~clk;

  axi_lite_split_mem #(.LATENCY(LAT)) dut (
    .CLK(clk), .RSTn(rstn),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every completed response handshake
  always @(negedge clk) begin
    if (rstn) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else check("bresp", 32'(bresp), 32'(exp_b.pop_front()));
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          rexp_t e;
          e = exp_r.pop_front();
          check("rdata", rdata, e.d);
          check("rresp", 32'(rresp), 32'(e.r));
        end
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er,
                         input int hold);
    int   lat;
    bit   ok;
    logic rdy;
    exp_r.push_back('{d: ed, r: er});
    @(posedge clk); #1;
    arvalid = 1'b1;
    araddr  = addr;
    rready  = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk); rdy = arready;
      @(posedge clk);
      if (rdy) begin ok = 1'b1; break; end
    end
    #1 arvalid = 1'b0;
    if (!ok) check("ar_timeout", 32'd1, 32'd0);
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
    if (!ok) check("r_timeout", 32'd1, 32'd0);
    else begin
      check("r_latency", 32'(lat), 32'(EXP_LAT));
      for (int i = 0; i < hold; i++) begin
        check("r_hold_valid", 32'(rvalid), 32'd1);
        check("r_hold_data", rdata, ed);
        check("r_hold_arready", 32'(arready), 32'd0);
        @(posedge clk); #1;
        if (i == hold - 1) rready = 1'b1;
        @(negedge clk);
      end
    end
    @(posedge clk); #1;
    rready = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int gap, input logic [1:0] er, input bit wait_b);
    if (wait_b) exp_b.push_back(er);
    fork
      begin
        bit ok; logic rdy;
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = addr;
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
          @(negedge clk); rdy = awready;
          @(posedge clk);
          if (rdy) begin ok = 1'b1; break; end
        end
        #1 awvalid = 1'b0;
        if (!ok) check("aw_timeout", 32'd1, 32'd0);
      end
      begin
        bit ok; logic rdy;
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        wvalid = 1'b1; wdata = data; wstrb = strb;
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
          @(negedge clk); rdy = wready;
          @(posedge clk);
          if (rdy) begin ok = 1'b1; break; end
        end
        #1 wvalid = 1'b0;
        if (!ok) check("w_timeout", 32'd1, 32'd0);
      end
    join
    if (wait_b) begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < BOUND; i++) begin
        @(negedge clk);
        if (bvalid) begin ok = 1'b1; break; end
      end
      if (!ok) check("b_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    dut.i_data[0]    = 32'h1234_5678;
    dut.i_data[1023] = 32'hCAFE_0001;
    dut.d_data[0]    = 32'h0000_00AB;
    dut.d_data[1]    = 32'h0;
    dut.d_data[2]    = 32'h0000_0022;
    dut.d_data[3]    = 32'h0;
    dut.d_data[1023] = 32'h0BAD_F00D;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_resps",   32'({bresp, rresp}), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    do_read(32'h0001_0000, 32'h0000_00AB, OKAY, 0);
    do_read(32'h0001_0001, 32'h0000_00AB, OKAY, 0);
    do_read(32'h0000_0000, 32'h1234_5678, OKAY, 0);
    do_read(32'h0000_0FFC, 32'hCAFE_0001, OKAY, 0);
    do_read(32'h0000_1000, 32'h0, DECERR, 0);
    do_read(32'h0001_0FFC, 32'h0BAD_F00D, OKAY, 0);
    do_read(32'h0001_1000, 32'h0, DECERR, 0);
    do_read(32'h0000_FFFC, 32'h0, DECERR, 0);

    do_write(32'h0001_0004, 32'hDEAD_BEEF, 4'b0101, 3, OKAY, 1'b1);
    do_read(32'h0001_0004, 32'h00AD_00EF, OKAY, 0);

    do_write(32'h0002_0000, 32'h1111_1111, 4'hF, 0, DECERR, 1'b1);
    do_read(32'h0002_0000, 32'h0, DECERR, 0);
    do_read(32'h0001_0000, 32'h0000_00AB, OKAY, 0);

    do_write(32'h0001_0000, 32'hFFFF_FFFF, 4'b0000, 1, OKAY, 1'b1);
    do_read(32'h0001_0000, 32'h0000_00AB, OKAY, 0);

    do_read(32'h0001_0004, 32'h00AD_00EF, OKAY, 5);

    fork
      do_write(32'h0001_0008, 32'h0000_0011, 4'hF, 0, OKAY, 1'b1);
      do_read(32'h0001_0008, 32'h0000_0022, OKAY, 0);
    join
    do_read(32'h0001_0008, 32'h0000_0011, OKAY, 0);

    bready = 1'b0;
    do_write(32'h0001_000C, 32'h0000_0055, 4'hF, 0, OKAY, 1'b0);
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < BOUND; i++) begin
        @(negedge clk);
        if (bvalid) begin ok = 1'b1; break; end
      end
      check("b_pending", 32'(ok), 32'd1);
    end
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    check("rst_bvalid_async", 32'(bvalid), 32'd0);
    check("rst_awready_async", 32'(awready), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    bready = 1'b1;
    do_read(32'h0001_000C, 32'h0000_0055, OKAY, 0);
    do_read(32'h0001_0000, 32'h0000_00AB, OKAY, 0);

    repeat (3) @(posedge clk);
    check("b_queue_empty", 32'(exp_b.size()), 32'd0);
    check("r_queue_empty", 32'(exp_r.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
